// File: rtl/xocc_pkg.sv
// Shared definitions for the XOCC command framer: state encoding, header layout, status codes.
package xocc_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned HDR_FLD_W = 8;

    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_ARGS     = 3'd1;
    localparam logic [STATE_W-1:0] ST_DRAIN    = 3'd2;
    localparam logic [STATE_W-1:0] ST_ISSUE    = 3'd3;
    localparam logic [STATE_W-1:0] ST_WAIT_RSP = 3'd4;
    localparam logic [STATE_W-1:0] ST_RSP_HDR  = 3'd5;
    localparam logic [STATE_W-1:0] ST_RSP_DATA = 3'd6;

    // Header word: [31:24] opcode, [23:16] tag, [15:8] reserved, [7:0] argc
    localparam int unsigned HDR_OPC_LSB  = 24;
    localparam int unsigned HDR_TAG_LSB  = 16;
    localparam int unsigned HDR_ARGC_LSB = 0;

    localparam logic [7:0] XOCC_ST_OK     = 8'h00;
    localparam logic [7:0] XOCC_ST_BADLEN = 8'h01;

    function automatic logic [31:0] rsp_hdr_word(input logic [7:0] opc,
                                                 input logic [7:0] tag,
                                                 input logic [7:0] status);
        return {opc, tag, 8'h00, status};
    endfunction

endpackage

// File: rtl/xocc_cmd_framer_if.sv
// Command FIFO, response FIFO and accelerator handshake bundle for one XOCC channel.
interface xocc_cmd_framer_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_ARGS = 4
);
    logic [DATA_W-1:0]          cmd_buffer;
    logic                       cmd_empty;
    logic                       cmd_rd_en;
    logic [DATA_W-1:0]          rsp_buffer;
    logic                       rsp_full;
    logic                       rsp_wr_en;
    logic                       acc_cmd_valid;
    logic                       acc_cmd_ready;
    logic [7:0]                 acc_cmd_opcode;
    logic [7:0]                 acc_cmd_tag;
    logic [7:0]                 acc_cmd_argc;
    logic [MAX_ARGS*DATA_W-1:0] acc_cmd_args;
    logic                       acc_rsp_valid;
    logic                       acc_rsp_ready;
    logic [7:0]                 acc_rsp_status;
    logic [DATA_W-1:0]          acc_rsp_data;
    logic                       busy;

    // Framer side
    modport master (
        input  cmd_buffer, cmd_empty, rsp_full, acc_cmd_ready,
               acc_rsp_valid, acc_rsp_status, acc_rsp_data,
        output cmd_rd_en, rsp_buffer, rsp_wr_en, acc_cmd_valid,
               acc_cmd_opcode, acc_cmd_tag, acc_cmd_argc, acc_cmd_args,
               acc_rsp_ready, busy
    );

    // FIFO / accelerator side
    modport slave (
        output cmd_buffer, cmd_empty, rsp_full, acc_cmd_ready,
               acc_rsp_valid, acc_rsp_status, acc_rsp_data,
        input  cmd_rd_en, rsp_buffer, rsp_wr_en, acc_cmd_valid,
               acc_cmd_opcode, acc_cmd_tag, acc_cmd_argc, acc_cmd_args,
               acc_rsp_ready, busy
    );
endinterface

// File: rtl/xocc_arg_regbank.sv
// Argument slot storage: MAX_ARGS words, bulk clear, indexed write, flat read-out.
module xocc_arg_regbank #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_ARGS = 4,
    parameter int unsigned IDX_W    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic                       we_i,
    input  logic [IDX_W-1:0]           idx_i,
    input  logic [DATA_W-1:0]          wdata_i,
    output logic [MAX_ARGS*DATA_W-1:0] args_o
);

    logic [MAX_ARGS*DATA_W-1:0] args_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            args_q <= '0;
        end else if (clr_i) begin
            args_q <= '0;
        end else if (we_i) begin
            for (int i = 0; i < int'(MAX_ARGS); i++) begin
                if (idx_i == IDX_W'(i)) begin
                    args_q[i*DATA_W +: DATA_W] <= wdata_i;
                end
            end
        end
    end

    assign args_o = args_q;

endmodule

// File: rtl/xocc_cmd_framer.sv
// XOCC channel endpoint: frames header+args from the command FIFO for the accelerator
// and returns a two-word {header, data} response; one command in flight at a time.
module xocc_cmd_framer
    import xocc_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_ARGS = 4
) (
    input  logic              i_pad_clk,
    input  logic              i_pad_rst_b,
    xocc_cmd_framer_if.master bus
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DCNT_W = 8;

    logic [STATE_W-1:0]   state_q, state_d;
    logic [HDR_FLD_W-1:0] opcode_q, opcode_d;
    logic [HDR_FLD_W-1:0] tag_q, tag_d;
    logic [HDR_FLD_W-1:0] argc_q, argc_d;
    logic [7:0]           status_q, status_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [CNT_W-1:0]     acnt_q, acnt_d;
    logic [DCNT_W-1:0]    dcnt_q, dcnt_d;
    logic [DATA_W-1:0]    rsp_buffer_q, rsp_buffer_d;
    logic                 acc_cmd_valid_q;
    logic                 acc_rsp_ready_q;
    logic                 busy_q;

    logic                 cmd_rd_en_c;
    logic                 rsp_wr_en_c;
    logic                 arg_clr_c;
    logic                 arg_we_c;

    logic [HDR_FLD_W-1:0] hdr_opc, hdr_tag, hdr_argc;
    logic [MAX_ARGS*DATA_W-1:0] args_flat;

    assign hdr_opc  = bus.cmd_buffer[HDR_OPC_LSB  +: HDR_FLD_W];
    assign hdr_tag  = bus.cmd_buffer[HDR_TAG_LSB  +: HDR_FLD_W];
    assign hdr_argc = bus.cmd_buffer[HDR_ARGC_LSB +: HDR_FLD_W];

    xocc_arg_regbank #(
        .DATA_W   (DATA_W),
        .MAX_ARGS (MAX_ARGS),
        .IDX_W    (CNT_W)
    ) u_args (
        .clk     (i_pad_clk),
        .rst_n   (i_pad_rst_b),
        .clr_i   (arg_clr_c),
        .we_i    (arg_we_c),
        .idx_i   (acnt_q),
        .wdata_i (bus.cmd_buffer),
        .args_o  (args_flat)
    );

    // Next-state, latch updates and FIFO strobes
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        tag_d       = tag_q;
        argc_d      = argc_q;
        status_d    = status_q;
        data_d      = data_q;
        acnt_d      = acnt_q;
        dcnt_d      = dcnt_q;
        cmd_rd_en_c = 1'b0;
        rsp_wr_en_c = 1'b0;
        arg_clr_c   = 1'b0;
        arg_we_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!bus.cmd_empty) begin
                    cmd_rd_en_c = 1'b1;
                    arg_clr_c   = 1'b1;
                    opcode_d    = hdr_opc;
                    tag_d       = hdr_tag;
                    argc_d      = hdr_argc;
                    acnt_d      = '0;
                    dcnt_d      = '0;
                    if (hdr_argc == '0) begin
                        state_d = ST_ISSUE;
                    end else if (hdr_argc > HDR_FLD_W'(MAX_ARGS)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_ARGS;
                    end
                end
            end
            ST_ARGS: begin
                if (!bus.cmd_empty) begin
                    cmd_rd_en_c = 1'b1;
                    arg_we_c    = 1'b1;
                    acnt_d      = acnt_q + CNT_W'(1);
                    if (HDR_FLD_W'(acnt_q) == argc_q - HDR_FLD_W'(1)) begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DRAIN: begin
                // Oversized packet: consume it and report BADLEN without touching the core
                if (!bus.cmd_empty) begin
                    cmd_rd_en_c = 1'b1;
                    dcnt_d      = dcnt_q + DCNT_W'(1);
                    if (dcnt_q == argc_q - DCNT_W'(1)) begin
                        status_d = XOCC_ST_BADLEN;
                        data_d   = '0;
                        state_d  = ST_RSP_HDR;
                    end
                end
            end
            ST_ISSUE: begin
                if (bus.acc_cmd_ready) begin
                    state_d = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (bus.acc_rsp_valid) begin
                    status_d = bus.acc_rsp_status;
                    data_d   = bus.acc_rsp_data;
                    state_d  = ST_RSP_HDR;
                end
            end
            ST_RSP_HDR: begin
                if (!bus.rsp_full) begin
                    rsp_wr_en_c = 1'b1;
                    state_d     = ST_RSP_DATA;
                end
            end
            ST_RSP_DATA: begin
                if (!bus.rsp_full) begin
                    rsp_wr_en_c = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Response word for the upcoming cycle, registered so rsp_buffer comes straight off a flop
        rsp_buffer_d = '0;
        if (state_d == ST_RSP_HDR) begin
            rsp_buffer_d = DATA_W'(rsp_hdr_word(opcode_d, tag_d, status_d));
        end else if (state_d == ST_RSP_DATA) begin
            rsp_buffer_d = data_d;
        end
    end

    always_ff @(posedge i_pad_clk or negedge i_pad_rst_b) begin
        if (!i_pad_rst_b) begin
            state_q         <= ST_IDLE;
            opcode_q        <= '0;
            tag_q           <= '0;
            argc_q          <= '0;
            status_q        <= XOCC_ST_OK;
            data_q          <= '0;
            acnt_q          <= '0;
            dcnt_q          <= '0;
            rsp_buffer_q    <= '0;
            acc_cmd_valid_q <= 1'b0;
            acc_rsp_ready_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            opcode_q        <= opcode_d;
            tag_q           <= tag_d;
            argc_q          <= argc_d;
            status_q        <= status_d;
            data_q          <= data_d;
            acnt_q          <= acnt_d;
            dcnt_q          <= dcnt_d;
            rsp_buffer_q    <= rsp_buffer_d;
            acc_cmd_valid_q <= (state_d == ST_ISSUE);
            acc_rsp_ready_q <= (state_d == ST_WAIT_RSP);
            busy_q          <= (state_d != ST_IDLE);
        end
    end

    assign bus.cmd_rd_en      = cmd_rd_en_c;
    assign bus.rsp_wr_en      = rsp_wr_en_c;
    assign bus.rsp_buffer     = rsp_buffer_q;
    assign bus.acc_cmd_valid  = acc_cmd_valid_q;
    assign bus.acc_cmd_opcode = opcode_q;
    assign bus.acc_cmd_tag    = tag_q;
    assign bus.acc_cmd_argc   = argc_q;
    assign bus.acc_cmd_args   = args_flat;
    assign bus.acc_rsp_ready  = acc_rsp_ready_q;
    assign bus.busy           = busy_q;

endmodule

// File: doc/xocc_cmd_framer.md
Name: xocc_cmd_framer

Overview:
- Accelerator-side endpoint of one XOCC channel of the dispatcher subsystem.
- Pops 32/64-bit words from the channel's command FIFO (cmd_buffer/cmd_empty/cmd_rd_en) and assembles header+argument packets.
- Presents each packet to the accelerator core over valid/ready, collects the result, and pushes a two-word response into the response FIFO (rsp_buffer/rsp_full/rsp_wr_en).
- Exactly one command is outstanding at a time.

Parameters:
- DATA_W, 32, FIFO word width; 32 or 64. Header/status fields use bits [31:0]; upper bits are zero on write and ignored on read.
- MAX_ARGS, 4, argument slots held for the accelerator (1..15).

Ports:
- i_pad_clk  in  1  sole clock, rising edge.
- i_pad_rst_b  in  1  asynchronous active-low reset.
- cmd_buffer  in  DATA_W  head of command FIFO; first-word-fall-through, valid while cmd_empty=0.
- cmd_empty  in  1  command FIFO empty.
- cmd_rd_en  out  1  pop command FIFO this cycle.
- rsp_buffer  out  DATA_W  word written to response FIFO.
- rsp_full  in  1  response FIFO full.
- rsp_wr_en  out  1  push rsp_buffer this cycle.
- acc_cmd_valid  out  1  packet valid to accelerator.
- acc_cmd_ready  in  1  accelerator accepts packet.
- acc_cmd_opcode  out  8  header opcode.
- acc_cmd_tag  out  8  header tag.
- acc_cmd_argc  out  8  argument count.
- acc_cmd_args  out  MAX_ARGS*DATA_W  argument words; slot i at [i*DATA_W +: DATA_W].
- acc_rsp_valid  in  1  accelerator result valid.
- acc_rsp_ready  out  1  block accepts result.
- acc_rsp_status  in  8  result status.
- acc_rsp_data  in  DATA_W  result data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0; args, opcode, tag, argc, count and latched result cleared; state IDLE. Reset may assert in any state, and the packet in flight is discarded (no partial response).
- Header word: [31:24] opcode, [23:16] tag, [15:8] reserved (ignored), [7:0] argc.
- cmd_rd_en = 1 only in IDLE/ARGS/DRAIN while cmd_empty=0; never asserted while cmd_empty=1.
- rsp_wr_en = 1 only in RSP_HDR/RSP_DATA while rsp_full=0; never asserted while rsp_full=1.
- IDLE, cmd_empty=0: pop; latch opcode/tag/argc; clear all arg slots; cnt=0.
  - argc=0 -> ISSUE.
  - argc>MAX_ARGS -> DRAIN.
  - otherwise -> ARGS.
- ARGS: each cycle with cmd_empty=0, pop into args[cnt] and increment cnt; after the pop with cnt==argc-1 -> ISSUE. An empty FIFO stalls in place.
- DRAIN: pop and discard argc words (same stall rule); after the last one, status=8'h01, data=0 -> RSP_HDR. The accelerator is not touched.
- ISSUE: acc_cmd_valid=1; opcode/tag/argc/args held stable. On acc_cmd_ready=1 -> WAIT_RSP. acc_cmd_valid never drops before ready.
- WAIT_RSP: acc_rsp_ready=1. On acc_rsp_valid=1, latch status/data -> RSP_HDR. acc_rsp_ready=0 in every other state.
- RSP_HDR: rsp_buffer = {opcode, tag, 8'h00, status}; push when !rsp_full -> RSP_DATA.
- RSP_DATA: rsp_buffer = latched data; push when !rsp_full -> IDLE.
- rsp_buffer is 0 outside RSP_HDR/RSP_DATA.
- Latency, header pop to acc_cmd_valid: argc+1 cycles with a continuously non-empty FIFO; 1 cycle for argc=0.
- Latency, acc_rsp_valid accepted to first rsp_wr_en: 1 cycle; the two response words go on consecutive cycles when not full.
- Back-to-back: the next header can be popped the cycle after the RSP_DATA push.
- The argument counter is 4 bits wide. The DRAIN counter is 8 bits wide, because argc=255 must drain 255 words.

Decomposition:
- Package xocc_pkg holds:
  - state enum (IDLE, ARGS, DRAIN, ISSUE, WAIT_RSP, RSP_HDR, RSP_DATA);
  - header field bit positions;
  - status codes XOCC_ST_OK=8'h00, XOCC_ST_BADLEN=8'h01.
- One sub-module, xocc_arg_regbank: MAX_ARGS x DATA_W registers with clear, write-enable and index inputs, and a flat output.

Test Plan:
- Header 0x12340002, args 0xA, 0xB, FIFO always non-empty -> acc_cmd_valid on cycle 3 after the first pop, args slots {0xB,0xA}, slots 2-3 = 0. Accelerator returns status 0, data 0x55 -> rsp words 0x12340000, 0x00000055.
- argc=0 header 0x07010000 -> acc_cmd_valid 1 cycle after the pop, no further cmd_rd_en until the response is written.
- Header argc=6 (MAX_ARGS=4) followed by 6 words -> 7 pops, acc_cmd_valid never asserted, rsp words {op,tag,00,01} and 0.
- cmd_empty toggling mid-ARGS and rsp_full held high for 5 cycles in RSP_HDR -> no rd_en/wr_en while empty/full, and the packet and response are unchanged.
- acc_cmd_ready held low for 10 cycles -> acc_cmd_valid and all acc_cmd_* stable. Response accepted exactly when acc_rsp_valid & acc_rsp_ready.
- Reset asserted in WAIT_RSP, then released -> all outputs 0, busy=0, no response word written; the next header is processed normally.
